// File: rtl/cordic_job_feeder.sv
// cordic_job_feeder: queues float angles in a small FIFO, runs them one at a
// time through the CORDIC cosine core, and returns each result with a timeout
// flag.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its data stable until that edge, and
// ready never depends on valid. Input side: in_valid/in_ready. Output side:
// out_valid/out_ready.
module cordic_job_feeder #(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int FIFO_ADDR_WIDTH  = 2,
  parameter int TIMEOUT_WIDTH    = 8,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int RELEASE_CYCLES   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FLOAT_DATA_WIDTH-1:0] in_angle,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [FLOAT_DATA_WIDTH-1:0] out_result,
  output logic                        out_timeout,
  output logic                        core_clk_en,
  output logic [FLOAT_DATA_WIDTH-1:0] core_angle,
  input  logic                        core_done,
  input  logic [FLOAT_DATA_WIDTH-1:0] core_result,
  output logic                        busy,
  output logic [FIFO_ADDR_WIDTH:0]    fifo_count,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int                          DEPTH    = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0]    FULL_CNT = (FIFO_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [TIMEOUT_WIDTH-1:0]    WD_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam int                          REL_W    = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [REL_W-1:0]            REL_LAST = REL_W'(RELEASE_CYCLES - 1);
  localparam logic [FLOAT_DATA_WIDTH-1:0] QNAN     = FLOAT_DATA_WIDTH'(32'h7FC0_0000);

  // Input FIFO storage and pointers
  logic [FLOAT_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_ADDR_WIDTH:0]    count_q, count_d;

  // Sequencer state and datapath registers
  state_e                      state_q, state_d;
  logic                        core_en_q, core_en_d;
  logic [FLOAT_DATA_WIDTH-1:0] core_angle_q, core_angle_d;
  logic [TIMEOUT_WIDTH-1:0]    wd_q, wd_d;
  logic [REL_W-1:0]            rel_q, rel_d;
  logic                        out_valid_q, out_valid_d;
  logic [FLOAT_DATA_WIDTH-1:0] out_result_q, out_result_d;
  logic                        out_timeout_q, out_timeout_d;

  logic push;
  logic issue;
  logic wd_expired;

  assign in_ready   = (count_q != FULL_CNT);
  assign push       = in_valid && in_ready;
  // A job is only issued with the result slot empty, so a done pulse always
  // has somewhere to land.
  assign issue      = (state_q == ST_IDLE) && (count_q != '0) && !out_valid_q;
  assign wd_expired = (wd_q == WD_LAST);

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)  wr_ptr_d = wr_ptr_q + FIFO_ADDR_WIDTH'(1);
    if (issue) rd_ptr_d = rd_ptr_q + FIFO_ADDR_WIDTH'(1);
    case ({push, issue})
      2'b10:   count_d = count_q + (FIFO_ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (FIFO_ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_angle;
  end

  // FIFO pointer/count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next-state: RELEASE waits out the hold time and for done to fall
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (issue) state_d = ST_RUN;
      ST_RUN:     if (core_done || wd_expired) state_d = ST_RELEASE;
      ST_RELEASE: if ((rel_q == REL_LAST) && !core_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: core drive, watchdog, release timer and result slot updates
  always_comb begin
    core_en_d     = core_en_q;
    core_angle_d  = core_angle_q;
    wd_d          = wd_q;
    rel_d         = rel_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          core_angle_d = mem_q[rd_ptr_q];
          core_en_d    = 1'b1;
          wd_d         = '0;
        end
      end
      ST_RUN: begin
        wd_d = wd_q + TIMEOUT_WIDTH'(1);
        // A done arriving on the watchdog's last cycle still reports the
        // real result.
        if (core_done) begin
          out_result_d  = core_result;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          core_en_d     = 1'b0;
          rel_d         = '0;
        end else if (wd_expired) begin
          out_result_d  = QNAN;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          core_en_d     = 1'b0;
          rel_d         = '0;
        end
      end
      ST_RELEASE: begin
        core_en_d = 1'b0;
        if (rel_q != REL_LAST) rel_d = rel_q + REL_W'(1);
      end
      default: begin
        core_en_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset drops core_clk_en at once, abandoning any job
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_en_q     <= 1'b0;
      core_angle_q  <= '0;
      wd_q          <= '0;
      rel_q         <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_timeout_q <= 1'b0;
    end else begin
      core_en_q     <= core_en_d;
      core_angle_q  <= core_angle_d;
      wd_q          <= wd_d;
      rel_q         <= rel_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign core_clk_en = core_en_q;
  assign core_angle  = core_angle_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;
  assign busy        = (state_q != ST_IDLE);
  assign fifo_count  = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cordic_job_feeder.sv
// Bench for cordic_job_feeder: a stand-in CORDIC core with programmable
// latency, a table of single-job vectors, and hand-written sequences for
// reset, watchdog, backpressure and burst behaviour.
module tb_cordic_job_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_angle;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_timeout;
  logic        core_clk_en;
  logic [31:0] core_angle;
  logic        core_done;
  logic [31:0] core_result;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // Stand-in core: done pulses on the core_lat-th cycle of clk_en (0 = never)
  int core_lat = 0;
  int run_cnt  = 0;

  cordic_job_feeder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_angle    (in_angle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_timeout (out_timeout),
    .core_clk_en (core_clk_en),
    .core_angle  (core_angle),
    .core_done   (core_done),
    .core_result (core_result),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .dbg_state   (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Overall time limit
  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // Stand-in core result: the two known cosines, otherwise sign-cleared angle + 1
  function automatic logic [31:0] stand_in(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h3F80_0000;
    else if (a == 32'h3F06_0A92) return 32'h3F5D_B3D7;
    else                         return {1'b0, a[30:0]} + 32'd1;
  endfunction

  // Core model, updated away from the active edge
  always @(negedge clk) begin
    if (core_clk_en) begin
      run_cnt   = run_cnt + 1;
      core_done = (core_lat != 0) && (run_cnt == core_lat);
    end else begin
      run_cnt   = 0;
      core_done = 1'b0;
    end
    core_result = stand_in(core_angle);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (busy && g < 50) begin
      @(negedge clk);
      g++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_en_low(input int limit);
    int g;
    g = 0;
    while (core_clk_en && g < limit) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic wait_en_high(input int limit);
    int g;
    g = 0;
    while (!core_clk_en && g < limit) begin
      @(negedge clk);
      g++;
    end
  endtask

  typedef struct {
    logic [31:0] angle;
    int          lat;
    int          run_len;
    logic [31:0] exp_res;
    logic        exp_to;
  } vec_t;

  vec_t        vec[7];
  logic [31:0] burst[6];
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] held;
  int          run_len, bad, guard;
  int          pushed, got, gap, gap_bad, jobs, max_cnt, rdy_bad, to_bad;
  logic        prev_en, will_push;

  initial begin
    // angle, core latency, RUN cycles, result, timeout
    vec[0] = '{32'h0000_0000,   5,   5, 32'h3F80_0000, 1'b0};
    vec[1] = '{32'h3F06_0A92,  10,  10, 32'h3F5D_B3D7, 1'b0};
    vec[2] = '{32'h4049_0FDB,   1,   1, 32'h4049_0FDC, 1'b0};
    vec[3] = '{32'hBF80_0000,   3,   3, 32'h3F80_0001, 1'b0};
    vec[4] = '{32'h3E00_0000,   0, 255, 32'h7FC0_0000, 1'b1};
    vec[5] = '{32'h3E80_0000, 255, 255, 32'h3E80_0001, 1'b0};
    vec[6] = '{32'h3F00_0000, 254, 254, 32'h3F00_0001, 1'b0};
    burst  = '{32'h3F80_0000, 32'h3F90_0000, 32'h3FA0_0000,
               32'h3FB0_0000, 32'h3FC0_0000, 32'h3FD0_0000};

    // Reset
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_angle  = '0;
    out_ready = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    #1;
    check("rst_clk_en",     core_clk_en, 1'b0);
    check("rst_core_angle", core_angle,  32'h0);
    check("rst_out_valid",  out_valid,   1'b0);
    check("rst_out_result", out_result,  32'h0);
    check("rst_out_to",     out_timeout, 1'b0);
    check("rst_busy",       busy,        1'b0);
    check("rst_fifo_count", fifo_count,  3'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    // Reset in the middle of a job, with a second angle queued
    core_lat = 0;
    in_valid = 1'b1;
    in_angle = 32'h3F00_0000;
    @(negedge clk);
    in_angle = 32'h3E00_0000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midjob_clk_en", core_clk_en, 1'b1);
    check("midjob_count",  fifo_count,  3'd1);
    check("midjob_busy",   busy,        1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_clk_en",    core_clk_en, 1'b0);
    check("arst_busy",      busy,        1'b0);
    check("arst_out_valid", out_valid,   1'b0);
    check("arst_count",     fifo_count,  3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_in_ready", in_ready,   1'b1);
    check("arst_count2",   fifo_count, 3'd0);
    check("arst_idle",     busy,       1'b0);

    // Single-job vectors
    for (int i = 0; i < 7; i++) begin
      core_lat = vec[i].lat;
      in_angle = vec[i].angle;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_not_yet", i), core_clk_en, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_issue_en", i),    core_clk_en, 1'b1);
      check($sformatf("v%0d_issue_angle", i), core_angle,  vec[i].angle);
      run_len = 0;
      bad     = 0;
      guard   = 0;
      while (core_clk_en && guard < 400) begin
        run_len++;
        if (core_angle !== vec[i].angle) bad++;
        guard++;
        @(negedge clk);
      end
      check($sformatf("v%0d_run_len", i),      run_len,     vec[i].run_len);
      check($sformatf("v%0d_angle_stable", i), bad,         0);
      check($sformatf("v%0d_out_valid", i),    out_valid,   1'b1);
      check($sformatf("v%0d_result", i),       out_result,  vec[i].exp_res);
      check($sformatf("v%0d_timeout", i),      out_timeout, vec[i].exp_to);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("v%0d_consumed", i), out_valid, 1'b0);
      wait_idle($sformatf("v%0d_idle", i));
    end

    // Watchdog expiry followed by a normal queued job
    core_lat = 0;
    in_valid = 1'b1;
    in_angle = 32'h3E00_0000;
    @(negedge clk);
    in_angle = 32'h3F40_0000;
    @(negedge clk);
    in_valid = 1'b0;
    wait_en_low(400);
    core_lat = 4;
    check("wd_valid",   out_valid,   1'b1);
    check("wd_result",  out_result,  32'h7FC0_0000);
    check("wd_timeout", out_timeout, 1'b1);
    check("wd_queued",  fifo_count,  3'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_en_high(20);
    check("wd_next_en",    core_clk_en, 1'b1);
    check("wd_next_angle", core_angle,  32'h3F40_0000);
    wait_en_low(20);
    check("wd_next_result",  out_result,  32'h3F40_0001);
    check("wd_next_timeout", out_timeout, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_idle("wd_idle");

    // Backpressure on the result slot
    core_lat = 4;
    in_valid = 1'b1;
    in_angle = 32'h4000_0000;
    @(negedge clk);
    in_angle = 32'h4040_0000;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("bp_first_result", out_result, 32'h4000_0001);
    held = out_result;
    bad  = 0;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || out_result !== held || core_clk_en || fifo_count != 3'd1) bad++;
    end
    check("bp_hold", bad, 0);
    check("bp_count", fifo_count, 3'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_consumed", out_valid,   1'b0);
    check("bp_no_issue", core_clk_en, 1'b0);
    @(negedge clk);
    check("bp_issue_en",    core_clk_en, 1'b1);
    check("bp_issue_angle", core_angle,  32'h4040_0000);
    wait_en_low(20);
    check("bp_second_result", out_result, 32'h4040_0001);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_idle("bp_idle");

    // Burst of six angles through a four-deep FIFO with the consumer always ready
    core_lat  = 3;
    out_ready = 1'b1;
    pushed = 0; got = 0; gap = 0; gap_bad = 0; jobs = 0;
    max_cnt = 0; rdy_bad = 0; to_bad = 0; guard = 0;
    prev_en = 1'b0;
    while (got < 6 && guard < 2000) begin
      if (in_ready !== (fifo_count != 3'd4)) rdy_bad++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check($sformatf("burst_unexpected_%0d", got), out_result, 32'hxxxx_xxxx);
        end else begin
          exp_v = exp_q.pop_front();
          check($sformatf("burst_result_%0d", got), out_result, exp_v);
        end
        if (out_timeout !== 1'b0) to_bad++;
        got++;
      end
      if (core_clk_en && !prev_en) begin
        if (jobs > 0 && gap != 3) gap_bad++;
        jobs++;
      end
      if (core_clk_en) gap = 0;
      else             gap++;
      prev_en = core_clk_en;
      if (pushed < 6) begin
        in_valid = 1'b1;
        in_angle = burst[pushed];
      end else begin
        in_valid = 1'b0;
      end
      will_push = in_valid && in_ready;
      if (will_push) begin
        exp_q.push_back(stand_in(in_angle));
        pushed++;
      end
      @(negedge clk);
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("burst_got",      got,          6);
    check("burst_pushed",   pushed,       6);
    check("burst_jobs",     jobs,         6);
    check("burst_max_cnt",  max_cnt,      4);
    check("burst_in_ready", rdy_bad,      0);
    check("burst_gap",      gap_bad,      0);
    check("burst_timeout",  to_bad,       0);
    check("burst_drained",  exp_q.size(), 0);
    wait_idle("burst_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
